bvule_bvneg_witness_checker: RTL
================================

// Module: bvule_bvneg_witness_checker
// PURPOSE
//  Sequential stimulus/check stage wrapped around the combinational Skolem witness for
//  "find x : bvule(bvneg(x), t)". Sweeps every t in [0, 2^W-1] into the Skolem block.
//  Samples the returned x and checks ((~x + 1) mod 2^W) <=u t.
//  Reports pass/fail counts and the first failing pair.
//  Sits directly upstream (drives t) and downstream (consumes x) of the Skolem block.
// PARAMETERS
//  W              4   operand width in bits; sweep length 2^W
//  SETTLE_CYCLES  1   cycles t_out is held before x_in is sampled (>=1)
// PORTS
//  clk            in   1    single clock, rising edge
//  rst_n          in   1    asynchronous, active-low reset
//  start          in   1    request a full sweep; honoured only in IDLE or DONE
//  busy           out  1    high from start acceptance until the done pulse
//  done           out  1    one-cycle pulse when the sweep ends
//  t_out          out  W    t operand driven to the Skolem block
//  x_in           in   W    witness x returned by the Skolem block
//  pass_cnt       out  W+1  vectors satisfying the check in the last/current sweep
//  fail_cnt       out  W+1  vectors violating the check
//  first_fail_vld out  1    a failure has been recorded this sweep
//  first_fail_t   out  W    t of the first failure
//  first_fail_x   out  W    x of the first failure
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, t_out=0, counters=0, first_fail_*=0.
//   Reset is async and takes effect mid-sweep: the sweep is abandoned, no done pulse.
//  FSM: IDLE -start-> SETTLE. SETTLE counts SETTLE_CYCLES cycles with t_out stable, then goes to CHECK.
//   CHECK lasts one cycle: x_in is sampled and compared.
//    If t_out != 2^W-1: t_out++ and return to SETTLE. Else go to DONE.
//   DONE: done=1 for exactly this one cycle, then IDLE. Results hold until the next start.
//  On start acceptance: t_out=0, counters and first_fail_* cleared, busy=1 the next cycle.
//  start while busy: ignored; no restart, no counter effect.
//  start in the DONE cycle: accepted; a new sweep begins the next cycle.
//  Latency: done asserted 2^W*(SETTLE_CYCLES+1)+1 cycles after the start edge.
//   W=4, S=1 gives 33.
//  Check arithmetic: neg = (~x_in + 1) truncated to W bits (x=0 -> 0); pass iff neg <= t_out (unsigned).
//  Counters are W+1 bits and never wrap: pass_cnt + fail_cnt = 2^W at done.
//  first_fail_* loaded on the first failing CHECK only; later failures do not overwrite.
//  t_out wrap: never increments past 2^W-1; the final CHECK leads to DONE, not to t=0.
// CONFIGURATION
//  SKOLEM_CHK_STOP_ON_FAIL_EN defined:
//   The first failing CHECK goes straight to DONE and the sweep stops.
//   pass_cnt = number of vectors before the failure, fail_cnt = 1, t_out frozen.
//  Not defined: the full sweep always runs (default).
// STRUCTURE
//  Shared package bvchk_pkg: state enum {IDLE, SETTLE, CHECK, DONE}, and
//   function bv_neg(x) for the W-bit two's-complement negate.
//  One sub-module: bvule_bvneg_cmp, a combinational (x, t) -> pass evaluator,
//   reused by the bench scoreboard.
//  Settle counter width: $clog2(SETTLE_CYCLES+1).
// TESTING
//  1 Model x=0 for all t, start -> done at cycle 33; pass_cnt=16, fail_cnt=0, first_fail_vld=0.
//  2 Model x=(-t mod 16) -> pass_cnt=16 (neg(x)=t <= t).
//  3 Faulty model x=1 -> pass_cnt=1 (t=15 only), fail_cnt=15, first_fail_t=0, first_fail_x=1.
//   With SKOLEM_CHK_STOP_ON_FAIL_EN: done at the first CHECK; fail_cnt=1, pass_cnt=0.
//  4 Pulse start again at cycle 10 while busy -> ignored; done still at cycle 33; counts unchanged vs case 1.
//  5 Deassert rst_n at cycle 12 -> all outputs 0 immediately; no done pulse.
//   Fresh start -> normal 33-cycle sweep.
//  6 SETTLE_CYCLES=3 -> t_out changes every 4 cycles; done at cycle 65;
//   x_in sampled only in the CHECK cycle (glitch injected during SETTLE must not count).

Source files
------------

// File: rtl/bvule_bvneg_witness_checker_pkg.sv
// bvchk_pkg: shared state encoding and the W-bit two's-complement negate
// used by the bvneg/bvule witness checker.
package bvchk_pkg;
   typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
   function automatic logic [31:0] bv_neg(input logic [31:0] x, input int unsigned w);
      return (~x + 32'd1) & ~(32'hFFFF_FFFF << w);
   endfunction
endpackage

// File: rtl/bvule_bvneg_witness_checker_cmp.sv
// bvule_bvneg_cmp: combinational check that bvneg(x) <=u t for one (x, t) pair.
module bvule_bvneg_cmp
   import bvchk_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] i_x,
   input  logic [W-1:0] i_t,
   output logic         o_pass
);
   logic [W-1:0] w_neg;
   assign w_neg  = W'(bv_neg(32'(i_x), W));
   assign o_pass = w_neg <= i_t;
endmodule

// File: rtl/bvule_bvneg_witness_checker.sv
// bvule_bvneg_witness_checker: sweeps t over [0, 2^W-1], checks bvneg(x) <=u t per vector.
// Optional macro SKOLEM_CHK_STOP_ON_FAIL_EN ends the sweep at the first failing vector.
module bvule_bvneg_witness_checker
   import bvchk_pkg::*;
#(
   parameter int W             = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] t_out,
   input  logic [W-1:0] x_in,
   output logic [W:0]   pass_cnt,
   output logic [W:0]   fail_cnt,
   output logic         first_fail_vld,
   output logic [W-1:0] first_fail_t,
   output logic [W-1:0] first_fail_x
);
   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [W-1:0]  T_MAX       = '1;

   state_t        r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic          w_pass, w_accept, w_settled, w_last;

   bvule_bvneg_cmp #(.W(W)) u_cmp (.i_x(x_in), .i_t(t_out), .o_pass(w_pass));

   assign w_accept  = start && (r_state == IDLE || r_state == DONE);
   assign w_settled = r_cnt == SETTLE_LAST;
`ifdef SKOLEM_CHK_STOP_ON_FAIL_EN
   assign w_last = (t_out == T_MAX) || !w_pass;
`else
   assign w_last = t_out == T_MAX;
`endif

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_accept ? SETTLE : IDLE;
         SETTLE:  w_next = w_settled ? CHECK : SETTLE;
         CHECK:   w_next = w_last ? DONE : SETTLE;
         DONE:    w_next = w_accept ? SETTLE : IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      busy = r_state == SETTLE || r_state == CHECK;
      done = r_state == DONE;
   end

   // x_in is only trusted in CHECK; anything it does during SETTLE is ignored
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_cnt          <= '0;
         t_out          <= '0;
         pass_cnt       <= '0;
         fail_cnt       <= '0;
         first_fail_vld <= 1'b0;
         first_fail_t   <= '0;
         first_fail_x   <= '0;
      end else begin
         r_cnt <= (r_state == SETTLE && !w_settled) ? r_cnt + 1'b1 : '0;
         if (w_accept) begin
            t_out          <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_vld <= 1'b0;
            first_fail_t   <= '0;
            first_fail_x   <= '0;
         end else if (r_state == CHECK) begin
            if (w_pass) pass_cnt <= pass_cnt + 1'b1;
            else begin
               fail_cnt <= fail_cnt + 1'b1;
               if (!first_fail_vld) begin
                  first_fail_vld <= 1'b1;
                  first_fail_t   <= t_out;
                  first_fail_x   <= x_in;
               end
            end
            if (!w_last) t_out <= t_out + 1'b1;
         end
      end
endmodule
